// File: rtl/i2s_stereo_receiver_pkg.sv
// Shared audio definitions for the I2S receive path.
package i2s_stereo_receiver_pkg;

  localparam int AUDIO_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF   = 6;

  // lrclk polarity: low selects the left channel
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  // Pin order inside the synchronizer bank
  localparam int PIN_BCLK  = 0;
  localparam int PIN_LRCLK = 1;
  localparam int PIN_SDATA = 2;
  localparam int NUM_PINS  = 3;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/i2s_stereo_receiver_if.sv
// Word stream from the receiver to the stereo parallelizer.
interface i2s_stereo_receiver_if
  import i2s_stereo_receiver_pkg::*;
#(
  parameter int audio_width = AUDIO_WIDTH_DEF
) ();

  logic                   o_valid;
  logic                   o_ready;
  logic                   o_is_left;
  logic [audio_width-1:0] o_audio;

  modport master (output o_valid, output o_is_left, output o_audio, input  o_ready);
  modport slave  (input  o_valid, input  o_is_left, input  o_audio, output o_ready);

endinterface

// File: rtl/i2s_stereo_receiver_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; clears to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2s_stereo_receiver.sv
// Philips-I2S receiver: oversamples bclk/lrclk/sdata in the clk domain and
// emits one MSB-aligned word per slot with a left/right tag.
module i2s_stereo_receiver
  import i2s_stereo_receiver_pkg::*;
#(
  parameter int audio_width = AUDIO_WIDTH_DEF,
  parameter int cnt_width   = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_bclk,
  input  logic                  i_lrclk,
  input  logic                  i_sdata,
  i2s_stereo_receiver_if.master bus,
  output logic                  o_overrun
);

  logic [NUM_PINS-1:0] pin_raw, pin_sync;

  assign pin_raw[PIN_BCLK]  = i_bclk;
  assign pin_raw[PIN_LRCLK] = i_lrclk;
  assign pin_raw[PIN_SDATA] = i_sdata;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pin_raw[g]),
      .q     (pin_sync[g])
    );
  end

  logic                   bclk_prev;
  logic                   lr_prev;
  logic [cnt_width-1:0]   cnt_q;
  logic [audio_width-1:0] shift_q;
  logic [audio_width-1:0] cap_word;
  logic                   rise, slot_edge, word_done;
  lock_state_e            state_q, state_d;

  // lrclk and sdata only matter on a synchronized bclk rising edge
  assign rise      = pin_sync[PIN_BCLK] & ~bclk_prev;
  assign slot_edge = rise & (pin_sync[PIN_LRCLK] != lr_prev);

  // Current shift word with this rise's bit dropped into its MSB-first slot;
  // bits past audio_width (including a saturated counter) match no position
  always_comb begin
    cap_word = shift_q;
    for (int i = 0; i < audio_width; i++) begin
      if (int'(cnt_q) == audio_width - 1 - i) cap_word[i] = pin_sync[PIN_SDATA];
    end
  end

  // Lock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_UNLOCKED;
    else       state_q <= state_d;
  end

  // The first slot boundary only locks: the slot that just ended was partial
  always_comb begin
    state_d   = state_q;
    word_done = 1'b0;
    if (slot_edge) begin
      if (state_q == ST_UNLOCKED) state_d   = ST_LOCKED;
      else                        word_done = 1'b1;
    end
  end

  // Slot framing: edge detect, bit counter and shift word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_prev <= 1'b0;
      lr_prev   <= LR_LEFT;
      cnt_q     <= '0;
      shift_q   <= '0;
    end else begin
      bclk_prev <= pin_sync[PIN_BCLK];
      if (rise) begin
        lr_prev <= pin_sync[PIN_LRCLK];
        if (slot_edge) begin
          // Boundary bit was the old slot's LSB; next rise is the new MSB
          cnt_q   <= '0;
          shift_q <= '0;
        end else begin
          shift_q <= cap_word;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Output holding register: a held word is never overwritten, newcomers
  // are dropped and flagged instead
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.o_valid   <= 1'b0;
      bus.o_is_left <= 1'b0;
      bus.o_audio   <= '0;
      o_overrun     <= 1'b0;
    end else if (word_done && (!bus.o_valid || bus.o_ready)) begin
      bus.o_valid   <= 1'b1;
      bus.o_is_left <= (lr_prev == LR_LEFT);
      bus.o_audio   <= cap_word;
    end else if (word_done) begin
      o_overrun     <= 1'b1;
    end else if (bus.o_valid && bus.o_ready) begin
      bus.o_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_stereo_receiver.sv
// Directed bench for i2s_stereo_receiver: slot tables plus hand sequences
// for lock, backpressure, simultaneous handoff and mid-slot reset.
module tb_i2s_stereo_receiver;
  import i2s_stereo_receiver_pkg::*;

  localparam int HALF = 4;  // clk edges per bclk phase: clk = 8x bclk

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_bclk = 1'b0, i_lrclk = 1'b0, i_sdata = 1'b0;
  logic o_overrun;

  i2s_stereo_receiver_if #(.audio_width(32)) bus ();

  i2s_stereo_receiver #(.audio_width(32), .cnt_width(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_bclk    (i_bclk),
    .i_lrclk   (i_lrclk),
    .i_sdata   (i_sdata),
    .bus       (bus),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lr;
    int          nbits;
    logic [31:0] data;
    int          extra;    // trailing 1-bits appended after the word
    bit          emit;
    logic        is_left;
    logic [31:0] exp;
  } slot_t;

  slot_t       tbl[8];
  int          ntbl;
  logic [32:0] rxq[$];
  logic [32:0] expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        pending  = 1'b0;
  logic        cur_lr   = 1'b0;

  // Record every completed handshake; sampled away from the active edge
  always @(negedge clk)
    if (!reset && bus.o_valid && bus.o_ready) rxq.push_back({bus.o_is_left, bus.o_audio});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic sd, input bit raise, input logic [32:0] sim_exp);
    i_lrclk = lr;
    i_sdata = sd;
    i_bclk  = 1'b0;
    for (int k = 0; k < HALF; k++) begin @(posedge clk); #1; end
    i_bclk = 1'b1;
    for (int k = 0; k < HALF; k++) begin
      @(posedge clk); #1;
      if (raise && k == 1) bus.o_ready = 1'b1;
      if (raise && k == 2) begin
        check("simul_valid",   bus.o_valid, 1'b1);
        check("simul_word",    {bus.o_is_left, bus.o_audio}, sim_exp);
        check("simul_overrun", o_overrun, 1'b0);
      end
    end
    i_bclk = 1'b0;
  endtask

  // One slot: first bit carries the previous slot's LSB, per the I2S delay
  task automatic send_slot(input logic lr, input int n, input logic [31:0] data,
                           input int extra, input bit raise, input logic [32:0] sim_exp);
    logic bits[$];
    for (int i = n - 1; i >= 0; i--) bits.push_back(data[i]);
    for (int i = 0; i < extra; i++) bits.push_back(1'b1);
    send_bit(lr, pending, raise, sim_exp);
    for (int i = 0; i < bits.size() - 1; i++) send_bit(lr, bits[i], 1'b0, '0);
    pending = bits[bits.size() - 1];
    cur_lr  = lr;
  endtask

  task automatic flush();
    send_bit(~cur_lr, pending, 1'b0, '0);
    send_bit(~cur_lr, 1'b0, 1'b0, '0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      send_slot(tbl[i].lr, tbl[i].nbits, tbl[i].data, tbl[i].extra, 1'b0, '0);
  endtask

  task automatic load_expected();
    for (int i = 0; i < ntbl; i++)
      if (tbl[i].emit) expq.push_back({tbl[i].is_left, tbl[i].exp});
  endtask

  task automatic compare_q(input string name);
    check({name, "_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < rxq.size()) check(name, rxq[i], expq[i]);
  endtask

  task automatic do_reset();
    i_bclk = 1'b0; i_lrclk = 1'b0; i_sdata = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pending = 1'b0;
    cur_lr  = 1'b0;
    rxq.delete();
    expq.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.o_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid",   bus.o_valid,   1'b0);
    check("rst_is_left", bus.o_is_left, 1'b0);
    check("rst_audio",   bus.o_audio,   32'h0);
    check("rst_overrun", o_overrun,     1'b0);

    // Normal capture with lock: partial left, then full slots
    bus.o_ready = 1'b1;
    tbl[0] = '{1'b0, 5,  32'h15,       0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32, 32'hDEADBEEF, 0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 32, 32'h80000001, 0, 1'b1, 1'b1, 32'h80000001};
    tbl[3] = '{1'b1, 32, 32'h7FFFFFFE, 0, 1'b1, 1'b0, 32'h7FFFFFFE};
    ntbl = 4;
    run_table(0, 2);
    check("lock_no_words", rxq.size(), 0);
    check("lock_no_valid", bus.o_valid, 1'b0);
    run_table(2, 4);
    flush();
    load_expected();
    compare_q("normal");
    check("normal_overrun", o_overrun, 1'b0);

    // Short 24-bit slots left-justify; an over-long slot truncates and saturates
    do_reset();
    bus.o_ready = 1'b1;
    tbl[0] = '{1'b0, 3,  32'h5,        0,  1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 24, 32'h000001,   0,  1'b1, 1'b0, 32'h00000100};
    tbl[2] = '{1'b0, 24, 32'hABCDEF,   0,  1'b1, 1'b1, 32'hABCDEF00};
    tbl[3] = '{1'b1, 24, 32'h123456,   0,  1'b1, 1'b0, 32'h12345600};
    tbl[4] = '{1'b0, 32, 32'h12345678, 40, 1'b1, 1'b1, 32'h12345678};
    ntbl = 5;
    run_table(0, 5);
    flush();
    load_expected();
    compare_q("short");

    // Backpressure: A held, B and C dropped, D and E pass after release
    do_reset();
    bus.o_ready = 1'b0;
    send_slot(1'b0, 4,  32'h3,        0, 1'b0, '0);
    send_slot(1'b1, 32, 32'h11111111, 0, 1'b0, '0);
    send_slot(1'b0, 32, 32'h22222222, 0, 1'b0, '0);
    send_slot(1'b1, 32, 32'h33333333, 0, 1'b0, '0);
    send_slot(1'b0, 32, 32'h44444444, 0, 1'b0, '0);
    check("bp_valid",   bus.o_valid, 1'b1);
    check("bp_held",    {bus.o_is_left, bus.o_audio}, {1'b0, 32'h11111111});
    check("bp_overrun", o_overrun, 1'b1);
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drain_valid",   bus.o_valid, 1'b0);
    check("bp_drain_count",   rxq.size(), 1);
    check("bp_sticky",        o_overrun, 1'b1);
    send_slot(1'b1, 32, 32'h55555555, 0, 1'b0, '0);
    flush();
    expq.push_back({1'b0, 32'h11111111});
    expq.push_back({1'b1, 32'h44444444});
    expq.push_back({1'b0, 32'h55555555});
    compare_q("bp");
    check("bp_sticky_end", o_overrun, 1'b1);

    // Ready rises on the very edge a new word completes
    do_reset();
    bus.o_ready = 1'b0;
    send_slot(1'b0, 4,  32'h9,        0, 1'b0, '0);
    send_slot(1'b1, 32, 32'h55AA55AA, 0, 1'b0, '0);
    send_slot(1'b0, 32, 32'h0F0F0F0F, 0, 1'b0, '0);
    send_slot(1'b1, 32, 32'hF0F0F0F1, 0, 1'b1, {1'b1, 32'h0F0F0F0F});
    flush();
    expq.push_back({1'b0, 32'h55AA55AA});
    expq.push_back({1'b1, 32'h0F0F0F0F});
    expq.push_back({1'b0, 32'hF0F0F0F1});
    compare_q("simul");
    check("simul_overrun_end", o_overrun, 1'b0);

    // Asynchronous reset 10 bclk into a left slot with a word held
    do_reset();
    bus.o_ready = 1'b0;
    send_slot(1'b0, 3,  32'h5,        0, 1'b0, '0);
    send_slot(1'b1, 32, 32'hCAFEF00D, 0, 1'b0, '0);
    send_slot(1'b0, 10, 32'h2AA,      0, 1'b0, '0);
    check("mid_held", bus.o_valid, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid",   bus.o_valid,   1'b0);
    check("mid_rst_is_left", bus.o_is_left, 1'b0);
    check("mid_rst_audio",   bus.o_audio,   32'h0);
    check("mid_rst_overrun", o_overrun,     1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.o_ready = 1'b1;
    rxq.delete();
    send_slot(1'b0, 22, 32'h155555,   0, 1'b0, '0);
    send_slot(1'b1, 32, 32'h600DF00D, 0, 1'b0, '0);
    send_slot(1'b0, 32, 32'h01234567, 0, 1'b0, '0);
    flush();
    expq.push_back({1'b0, 32'h600DF00D});
    expq.push_back({1'b1, 32'h01234567});
    compare_q("mid_relock");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_stereo_receiver.md
Name: i2s_stereo_receiver

Overview:
- Front-end stage of the echo-effect audio path. Recovers Philips-I2S serial audio from the ADC/codec pins (bclk, lrclk, sdata), all oversampled in the clk domain.
- Emits one channel word per slot, with a left/right tag, on a valid/ready stream.
- The stream feeds the stereo parallelizer directly: o_valid/o_ready/o_is_left/o_audio connect to its i_valid/i_ready/i_is_left/i_audio.

Parameters:
- audio_width, 32: width of emitted word; slots longer are truncated, shorter are left-justified.
- cnt_width, 6: width of per-slot bit counter; must satisfy 2^cnt_width > max bclk periods per slot.

Ports:
- clk  input  1  system clock; must be at least 4x the bclk frequency.
- reset  input  1  reset, asynchronous, active-high.
- i_bclk  input  1  I2S bit clock, asynchronous to clk.
- i_lrclk  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
- i_sdata  input  1  I2S serial data, MSB first, one-bclk delay after the lrclk change.
- o_valid  output  1  word available.
- o_ready  input  1  downstream accepts word.
- o_is_left  output  1  1 = word belongs to the left channel.
- o_audio  output  audio_width  captured word, two's complement, MSB-aligned.
- o_overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Input conditioning
  - i_bclk, i_lrclk and i_sdata each pass through a 2-FF synchronizer.
  - A third register holds the previous synchronized bclk.
  - rise = sync_bclk & !prev_bclk.
  - lrclk and sdata are sampled only on rise.
- Slot framing
  - lr_prev holds lrclk as sampled at the previous rise.
  - At a rise where the sampled lrclk differs from lr_prev, the sampled sdata bit is the LSB (final bit) of the slot just ending, per the I2S one-bit delay.
  - At that rise, the word completes with is_left = !lr_prev.
  - The bit counter clears so the next rise captures the MSB of the new slot.
- Bit placement
  - The shift word is cleared at slot start.
  - The bit captured at counter value n is written to bit (audio_width-1-n) while n < audio_width; later bits are ignored.
  - The counter saturates at its maximum and does not wrap.
  - Slots shorter than audio_width leave the LSBs zero. Example: 24-bit slot into 32 bits gives word = sample<<8.
- Lock
  - After reset, the locked flag is 0.
  - The first lrclk transition sets locked and emits nothing, because that slot is partial.
  - Words are emitted only while locked.
- Output register
  - On word completion with !o_valid, or with o_valid && o_ready in the same clk: load o_audio/o_is_left and set o_valid=1.
  - On word completion with o_valid && !o_ready: discard the new word, keep the held word unchanged, set o_overrun=1.
  - On o_valid && o_ready without completion: o_valid=0 next clk.
  - o_audio/o_is_left are stable while o_valid && !o_ready.
  - o_valid never depends combinationally on o_ready.
- Latency: o_valid rises on the 3rd clk edge counting the first edge that samples i_bclk=1, i.e. 2 sync stages plus 1 output register.
- Reset state
  - Outputs: o_valid=0, o_is_left=0, o_audio=0, o_overrun=0.
  - Internal: synchronizers 0, counter 0, locked 0, lr_prev 0.
  - Reset mid-slot discards the partial word; the lock sequence restarts.
- lrclk held constant (clock stopped or mono source): no emission; the counter saturates. No timeout.
- bclk stopped: state is frozen; a held o_valid stays held.

Decomposition:
- Shared audio package: LR_LEFT=0 / LR_RIGHT=1 lrclk polarity constants, default audio_width.
- Sub-module sync_2ff, one instance per pin. It is generic, reusable by other I2S/clock-domain blocks, and has reset to 0.
- Framing, bit placement and output register are kept inline.

Test Plan:
- Normal capture: audio_width=32, 32-bit slots, clk=8x bclk, o_ready=1. Send L=0x80000001 then R=0x7FFFFFFE after one lock slot.
  - Required: two words, is_left=1 with 0x80000001 then is_left=0 with 0x7FFFFFFE; o_overrun stays 0.
- Short slot: 24-bit slots, L=0xABCDEF, R=0x123456.
  - Required: o_audio=0xABCDEF00 then 0x12345600.
- Lock: first partial slot after reset deasserts mid-frame.
  - Required: no o_valid until the second lrclk transition completes; the first emitted word equals the first full slot.
- Backpressure: o_ready=0 across two word completions.
  - Required: first word held stable, second dropped, o_overrun=1 and sticky. Raising o_ready then gives one transfer, and the next word is accepted normally.
- Simultaneous: o_ready rises on the exact clk edge a new word completes.
  - Required: the held word transfers, the new word loads, o_valid stays 1, no overrun.
- Reset mid-slot: assert reset 10 bclk into a left slot.
  - Required: all outputs 0 immediately (asynchronous); after release, lock is re-acquired and no partial word is emitted.
